sound_latch_bridge: RTL and testbench
=====================================

// Module: sound_latch_bridge
// PURPOSE
//  Bidirectional byte mailbox between the M68K main CPU and the Z80 sound CPU.
//  - Forward path (soundlatch): M68K write latch -> Z80 read at 0xF800.
//  - Reply path (soundlatch2): Z80 write at 0xF800 -> M68K read at 0x0F8000.
//  Raises the Z80 maskable IRQ on every forward write and serves the IM0/IM2
//  vector during acknowledge. Consumes the chip selects from the address decoder.
// PARAMETERS
//  IRQ_VECTOR     8'hFF  byte driven on z80_int_vector during INT ack (0xFF = RST 38h)
//  REPLY_HI_BYTE  8'hFF  upper byte returned on m68k_latch_dout[15:8]
//  CLEAR_ON_READ  1      1: M68K read of the reply latch clears reply_pending
// PORTS
//  clk                input   1   system clock
//  reset              input   1   synchronous, active-high reset
//  m68k_latch_cs      input   1   M68K write strobe to soundlatch (decoded, write-qualified)
//  m68k_din           input   16  M68K write data; bits [7:0] used
//  z80_latch_read_cs  input   1   M68K read strobe of soundlatch2
//  m68k_latch_dout    output  16  {REPLY_HI_BYTE, reply latch}
//  z80_latch_cs       input   1   Z80 MREQ access to 0xF800
//  z80_rd_n           input   1   Z80 RD_n
//  z80_wr_n           input   1   Z80 WR_n
//  z80_din            input   8   Z80 write data
//  z80_latch_dout     output  8   forward latch contents to the Z80 data mux
//  M1_n               input   1   Z80 M1_n
//  IORQ_n             input   1   Z80 IORQ_n
//  z80_irq_n          output  1   Z80 INT_n, active-low
//  z80_int_vector     output  8   IRQ_VECTOR while z80_int_vec_oe = 1, else 8'h00
//  z80_int_vec_oe     output  1   high while acknowledge is in progress and the IRQ is pending
//  sound_pending      output  1   forward latch written, not yet read by the Z80
//  reply_pending      output  1   reply latch written, not yet read by the M68K
//  overrun            output  1   sticky: forward write while sound_pending = 1
// BEHAVIOUR
//  Reset: both latches 8'h00; z80_irq_n = 1; sound_pending, reply_pending,
//    overrun = 0; z80_int_vec_oe = 0; IRQ FSM = IDLE. Edge-detector history registers
//    cleared to 0.
//  Strobe qualification: every event fires on the rising edge of its strobe, registered
//    once, so a multi-cycle bus access counts as exactly one event.
//    - fwd_wr = rise(m68k_latch_cs)
//    - fwd_rd = rise(z80_latch_cs & ~z80_rd_n)
//    - rep_wr = rise(z80_latch_cs & ~z80_wr_n)
//    - rep_rd = rise(z80_latch_read_cs)
//    - ack    = ~M1_n & ~IORQ_n
//  Write capture: the latch is updated on the fwd_wr/rep_wr cycle. The new value is
//    visible on the *_dout outputs the following cycle.
//  Read data outputs are combinational from the latches: z80_latch_dout = fwd latch,
//    m68k_latch_dout[7:0] = reply latch. A read never alters latch contents.
//  sound_pending: set on fwd_wr; cleared on fwd_rd. Simultaneous fwd_wr and fwd_rd:
//    set wins. overrun sets on fwd_wr when sound_pending = 1 and holds until reset.
//  reply_pending: set on rep_wr; cleared on rep_rd when CLEAR_ON_READ = 1.
//    Simultaneous set and clear: set wins.
//  IRQ FSM:
//    - IDLE  : z80_irq_n = 1. fwd_wr -> ASSERT.
//    - ASSERT: z80_irq_n = 0. ack -> ACK.
//    - ACK   : z80_irq_n = 0, z80_int_vec_oe = 1 while ack holds.
//        - When ack drops: -> IDLE; or -> ASSERT if a fwd_wr occurred during ACK
//          (tracked by a re_arm flag).
//    - fwd_wr in ASSERT: no state change, since the IRQ is already pending.
//    - z80_irq_n is registered: low the cycle after fwd_wr, high the cycle after ack
//      drops (unless re-armed).
//  z80_int_vector = IRQ_VECTOR when z80_int_vec_oe = 1, else 8'h00.
//  Reset mid-operation, including mid-acknowledge: all state returns to reset values
//    on the next clock. No IRQ is re-raised until a new fwd_wr.
// TESTING
//  - Reset, then M68K writes 0x1234 with cs held 6 cycles
//    -> fwd latch = 0x34; one event; sound_pending = 1; z80_irq_n low 1 cycle later.
//  - Z80 ack (M1_n = IORQ_n = 0 for 3 cycles)
//    -> z80_int_vector = 0xFF with oe = 1 during ack; z80_irq_n = 1 one cycle after ack ends.
//  - Z80 reads 0xF800 -> z80_latch_dout = 0x34; sound_pending = 0; overrun stays 0.
//  - Two M68K writes 0xA5 then 0x5A with no Z80 read
//    -> latch = 0x5A; overrun = 1; only one IRQ outstanding.
//  - Z80 writes 0x77; M68K reads soundlatch2
//    -> m68k_latch_dout = 0xFF77; reply_pending 1 -> 0.
//  - M68K write during ACK
//    -> after ack drops, FSM returns to ASSERT and z80_irq_n stays 0.
//  - reset asserted mid-ASSERT -> z80_irq_n = 1 and all flags 0 next cycle.

Source files
------------

// File: rtl/sound_latch_bridge.sv
// sound_latch_bridge
// Two one-byte mailboxes between the M68K main CPU and the Z80 sound CPU.
// The forward latch (M68K -> Z80) raises the Z80 maskable interrupt on each
// write. The bridge drives the interrupt vector during the Z80 acknowledge
// cycle. The reply latch (Z80 -> M68K) carries status bytes back.
// Each bus strobe is reduced to a single-cycle event on its rising edge.
// A bus access that lasts several cycles therefore counts only once.

module sound_latch_bridge #(
    parameter logic [7:0] IRQ_VECTOR    = 8'hFF,
    parameter logic [7:0] REPLY_HI_BYTE = 8'hFF,
    parameter bit         CLEAR_ON_READ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    // M68K side
    input  logic        m68k_latch_cs,
    input  logic [15:0] m68k_din,
    input  logic        z80_latch_read_cs,
    output logic [15:0] m68k_latch_dout,
    // Z80 side
    input  logic        z80_latch_cs,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic [7:0]  z80_din,
    output logic [7:0]  z80_latch_dout,
    input  logic        M1_n,
    input  logic        IORQ_n,
    output logic        z80_irq_n,
    output logic [7:0]  z80_int_vector,
    output logic        z80_int_vec_oe,
    // status
    output logic        sound_pending,
    output logic        reply_pending,
    output logic        overrun
);

    // Strobe bit positions in the edge-detector vector
    localparam int EV_FWD_WR = 0;
    localparam int EV_FWD_RD = 1;
    localparam int EV_REP_WR = 2;
    localparam int EV_REP_RD = 3;
    localparam int N_EV      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACK    = 2'd2
    } irq_state_t;

    // Only the low byte of the M68K bus carries latch data
    logic unused_din_hi;
    assign unused_din_hi = ^m68k_din[15:8];

    // ------------------------------------------------------------------
    // Strobe qualification
    // ------------------------------------------------------------------
    logic [N_EV-1:0] strobe_raw;
    logic [N_EV-1:0] strobe_hist_q;
    logic [N_EV-1:0] strobe_hist_d;
    logic [N_EV-1:0] strobe_rise;

    assign strobe_raw[EV_FWD_WR] = m68k_latch_cs;
    assign strobe_raw[EV_FWD_RD] = z80_latch_cs & ~z80_rd_n;
    assign strobe_raw[EV_REP_WR] = z80_latch_cs & ~z80_wr_n;
    assign strobe_raw[EV_REP_RD] = z80_latch_read_cs;

    // A strobe event fires only in the first cycle the strobe is seen high
    genvar gi;
    generate
        for (gi = 0; gi < N_EV; gi++) begin : g_edge
            assign strobe_rise[gi] = strobe_raw[gi] & ~strobe_hist_q[gi];
        end
    endgenerate

    logic fwd_wr;
    logic fwd_rd;
    logic rep_wr;
    logic rep_rd;
    logic ack;

    assign fwd_wr = strobe_rise[EV_FWD_WR];
    assign fwd_rd = strobe_rise[EV_FWD_RD];
    assign rep_wr = strobe_rise[EV_REP_WR];
    assign rep_rd = strobe_rise[EV_REP_RD];
    // The acknowledge is level-sensitive and lasts as long as the Z80 holds it
    assign ack    = ~M1_n & ~IORQ_n;

    // The reply flag may be cleared by an M68K read, or left for polling code to handle
    logic rep_clr;
    generate
        if (CLEAR_ON_READ) begin : g_clr_on_read
            assign rep_clr = rep_rd;
        end else begin : g_no_clr
            assign rep_clr = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Latches and status flags
    // ------------------------------------------------------------------
    logic [7:0] fwd_latch_q;
    logic [7:0] fwd_latch_d;
    logic [7:0] rep_latch_q;
    logic [7:0] rep_latch_d;
    logic       sound_pending_q;
    logic       sound_pending_d;
    logic       reply_pending_q;
    logic       reply_pending_d;
    logic       overrun_q;
    logic       overrun_d;

    // Next-state logic for latches and flags; when set and clear happen together, set wins
    always_comb begin
        strobe_hist_d   = strobe_raw;
        fwd_latch_d     = fwd_latch_q;
        rep_latch_d     = rep_latch_q;
        sound_pending_d = sound_pending_q;
        reply_pending_d = reply_pending_q;
        overrun_d       = overrun_q;

        if (fwd_wr) begin
            fwd_latch_d = m68k_din[7:0];
        end
        if (rep_wr) begin
            rep_latch_d = z80_din;
        end

        if (fwd_wr) begin
            sound_pending_d = 1'b1;
        end else if (fwd_rd) begin
            sound_pending_d = 1'b0;
        end

        if (rep_wr) begin
            reply_pending_d = 1'b1;
        end else if (rep_clr) begin
            reply_pending_d = 1'b0;
        end

        // Sticky: the Z80 missed a command byte
        if (fwd_wr && sound_pending_q) begin
            overrun_d = 1'b1;
        end
    end

    // Register latches, flags and the strobe history
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_hist_q   <= '0;
            fwd_latch_q     <= 8'h00;
            rep_latch_q     <= 8'h00;
            sound_pending_q <= 1'b0;
            reply_pending_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            strobe_hist_q   <= strobe_hist_d;
            fwd_latch_q     <= fwd_latch_d;
            rep_latch_q     <= rep_latch_d;
            sound_pending_q <= sound_pending_d;
            reply_pending_q <= reply_pending_d;
            overrun_q       <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // IRQ state machine
    // ------------------------------------------------------------------
    irq_state_t state_q;
    irq_state_t state_d;
    logic       re_arm_q;
    logic       re_arm_d;
    logic       irq_n_q;
    logic       irq_n_d;
    logic       vec_oe_q;
    logic       vec_oe_d;

    // Next state plus outputs; the outputs are registered and so follow the state with no extra lag
    always_comb begin
        state_d  = state_q;
        re_arm_d = re_arm_q;
        case (state_q)
            ST_IDLE: begin
                re_arm_d = 1'b0;
                if (fwd_wr) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // A further write here needs no action: the IRQ is already pending
                re_arm_d = 1'b0;
                if (ack) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ack) begin
                    re_arm_d = re_arm_q | fwd_wr;
                end else begin
                    // A write during the acknowledge must not be lost; raise the IRQ again
                    state_d  = (re_arm_q || fwd_wr) ? ST_ASSERT : ST_IDLE;
                    re_arm_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                re_arm_d = 1'b0;
            end
        endcase

        irq_n_d  = (state_d == ST_IDLE);
        vec_oe_d = (state_d == ST_ACK);
    end

    // Register the IRQ state and its outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            re_arm_q <= 1'b0;
            irq_n_q  <= 1'b1;
            vec_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            re_arm_q <= re_arm_d;
            irq_n_q  <= irq_n_d;
            vec_oe_q <= vec_oe_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign z80_latch_dout  = fwd_latch_q;
    assign m68k_latch_dout = {REPLY_HI_BYTE, rep_latch_q};
    assign z80_irq_n       = irq_n_q;
    assign z80_int_vec_oe  = vec_oe_q;
    assign z80_int_vector  = vec_oe_q ? IRQ_VECTOR : 8'h00;
    assign sound_pending   = sound_pending_q;
    assign reply_pending   = reply_pending_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Directed bench for sound_latch_bridge. The bench drives inputs and samples
// outputs 1 ns after each rising clock edge.
`timescale 1ns/1ps
module tb_sound_latch_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        m68k_latch_cs;
    logic [15:0] m68k_din;
    logic        z80_latch_read_cs;
    logic [15:0] m68k_latch_dout;
    logic        z80_latch_cs;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic [7:0]  z80_din;
    logic [7:0]  z80_latch_dout;
    logic        M1_n;
    logic        IORQ_n;
    logic        z80_irq_n;
    logic [7:0]  z80_int_vector;
    logic        z80_int_vec_oe;
    logic        sound_pending;
    logic        reply_pending;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sound_latch_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .m68k_latch_cs     (m68k_latch_cs),
        .m68k_din          (m68k_din),
        .z80_latch_read_cs (z80_latch_read_cs),
        .m68k_latch_dout   (m68k_latch_dout),
        .z80_latch_cs      (z80_latch_cs),
        .z80_rd_n          (z80_rd_n),
        .z80_wr_n          (z80_wr_n),
        .z80_din           (z80_din),
        .z80_latch_dout    (z80_latch_dout),
        .M1_n              (M1_n),
        .IORQ_n            (IORQ_n),
        .z80_irq_n         (z80_irq_n),
        .z80_int_vector    (z80_int_vector),
        .z80_int_vec_oe    (z80_int_vec_oe),
        .sound_pending     (sound_pending),
        .reply_pending     (reply_pending),
        .overrun           (overrun)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m68k_write(input logic [15:0] d);
        m68k_din = d;
        m68k_latch_cs = 1'b1;
        tick();
        m68k_latch_cs = 1'b0;
        tick();
    endtask

    task automatic set_ack(input logic on);
        M1_n   = ~on;
        IORQ_n = ~on;
    endtask

    initial begin
        reset = 1'b1;
        m68k_latch_cs = 1'b0; m68k_din = 16'h0000; z80_latch_read_cs = 1'b0;
        z80_latch_cs = 1'b0; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_din = 8'h00;
        M1_n = 1'b1; IORQ_n = 1'b1;
        tick(2);
        check("rst_irq_n", {15'd0, z80_irq_n}, 16'd1);
        check("rst_flags", {13'd0, sound_pending, reply_pending, overrun}, 16'd0);
        check("rst_oe_vec", {7'd0, z80_int_vec_oe, z80_int_vector}, 16'h0000);
        check("rst_z80_dout", {8'd0, z80_latch_dout}, 16'h0000);
        check("rst_m68k_dout", m68k_latch_dout, 16'hFF00);
        reset = 1'b0;
        tick();

        // M68K writes 0x1234 while holding cs for 6 cycles
        m68k_din = 16'h1234; m68k_latch_cs = 1'b1;
        check("t1_irq_before", {15'd0, z80_irq_n}, 16'd1);
        tick();
        check("t1_latch", {8'd0, z80_latch_dout}, 16'h0034);
        check("t1_pending", {15'd0, sound_pending}, 16'd1);
        check("t1_irq_low", {15'd0, z80_irq_n}, 16'd0);
        m68k_din = 16'hBEEF;
        tick(5);
        check("t1_one_event_latch", {8'd0, z80_latch_dout}, 16'h0034);
        check("t1_one_event_ovr", {15'd0, overrun}, 16'd0);
        m68k_latch_cs = 1'b0;
        tick();

        // Z80 acknowledge for 3 cycles
        set_ack(1'b1);
        check("t2_oe_before", {15'd0, z80_int_vec_oe}, 16'd0);
        tick();
        check("t2_oe_vec", {7'd0, z80_int_vec_oe, z80_int_vector}, 16'h01FF);
        check("t2_irq_in_ack", {15'd0, z80_irq_n}, 16'd0);
        tick(2);
        set_ack(1'b0);
        check("t2_oe_last", {15'd0, z80_int_vec_oe}, 16'd1);
        tick();
        check("t2_irq_release", {15'd0, z80_irq_n}, 16'd1);
        check("t2_oe_vec_off", {7'd0, z80_int_vec_oe, z80_int_vector}, 16'h0000);

        // Z80 reads 0xF800
        z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
        tick();
        check("t3_dout", {8'd0, z80_latch_dout}, 16'h0034);
        check("t3_pending_clr", {15'd0, sound_pending}, 16'd0);
        check("t3_ovr", {15'd0, overrun}, 16'd0);
        tick();
        z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
        tick();

        // Two writes with no Z80 read in between
        m68k_write(16'h00A5);
        check("t4_ovr_first", {15'd0, overrun}, 16'd0);
        m68k_write(16'h005A);
        check("t4_latch", {8'd0, z80_latch_dout}, 16'h005A);
        check("t4_ovr", {15'd0, overrun}, 16'd1);
        check("t4_irq", {15'd0, z80_irq_n}, 16'd0);
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        tick();
        check("t4_single_irq", {15'd0, z80_irq_n}, 16'd1);

        // Z80 reply, then M68K reads it
        z80_din = 8'h77; z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
        tick();
        z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
        check("t5_rep_pend", {15'd0, reply_pending}, 16'd1);
        check("t5_m68k_dout", m68k_latch_dout, 16'hFF77);
        tick();
        z80_latch_read_cs = 1'b1;
        tick();
        z80_latch_read_cs = 1'b0;
        check("t5_rep_clr", {15'd0, reply_pending}, 16'd0);
        check("t5_dout_kept", m68k_latch_dout, 16'hFF77);
        tick();

        // M68K write during the acknowledge re-arms the IRQ
        m68k_write(16'h0011);
        set_ack(1'b1);
        tick();
        m68k_din = 16'h0022; m68k_latch_cs = 1'b1;
        tick();
        m68k_latch_cs = 1'b0;
        tick();
        set_ack(1'b0);
        tick();
        check("t6_rearm_irq", {15'd0, z80_irq_n}, 16'd0);
        check("t6_rearm_oe", {15'd0, z80_int_vec_oe}, 16'd0);
        check("t6_latch", {8'd0, z80_latch_dout}, 16'h0022);
        tick(2);
        check("t6_irq_held", {15'd0, z80_irq_n}, 16'd0);
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        tick();
        check("t6_irq_done", {15'd0, z80_irq_n}, 16'd1);

        // Reset while ASSERT is active, with a reply pending
        z80_din = 8'h55; z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
        tick();
        z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
        m68k_write(16'h0033);
        check("t7_pre_irq", {15'd0, z80_irq_n}, 16'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_irq_n", {15'd0, z80_irq_n}, 16'd1);
        check("t7_flags", {13'd0, sound_pending, reply_pending, overrun}, 16'd0);
        check("t7_latches", {z80_latch_dout, m68k_latch_dout[7:0]}, 16'h0000);
        tick(3);
        check("t7_no_reraise", {15'd0, z80_irq_n}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
